// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction buffer and sequencer driving the riscv_simple datapath
// Optional issued-instruction counter is built when SEQ_CYCLE_COUNT_EN is defined.
module instr_sequencer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              start,
   input  logic              halt_req,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              branch_taken,
   output logic [ADDR_W-1:0] pc,
   output logic              done,
   output logic              error,
   output logic [15:0]       cycle_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int         TW     = ADDR_W + 11;

   logic [1:0]           state;
   logic [31:0]          mem [DEPTH];
   logic [ADDR_W-1:0]    pc_q;
   logic [31:0]          cur;
   logic [12:1]          imm;
   logic signed [TW-1:0] target;
   logic                 target_bad;
   logic                 is_sentinel;

   assign cur         = mem[pc_q];
   assign is_sentinel = (cur == 32'h0);

   // B-type immediate; bit 0 is always zero so only [12:1] is kept
   assign imm    = {cur[31], cur[7], cur[30:25], cur[11:8]};
   assign target = $signed({11'b0, pc_q}) + $signed({{ADDR_W{imm[12]}}, imm[12:2]});

   // Out of range means negative or any bit at or above ADDR_W; a half-word offset is also illegal
   assign target_bad = target[TW-1] | (|target[TW-2:ADDR_W]) | imm[1];

   assign instr       = (state == S_RUN) ? cur : 32'h0;
   assign instr_valid = (state == S_RUN) && !is_sentinel;
   assign load_ready  = (state == S_IDLE);
   assign pc          = pc_q;

   always_ff @(posedge clk) begin
      if (load_valid && state == S_IDLE) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         pc_q  <= '0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state <= S_RUN;
                  pc_q  <= '0;
                  done  <= 1'b0;
                  error <= 1'b0;
               end else if (halt_req && state == S_DONE) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
                  error <= 1'b0;
               end
            end
            S_RUN: begin
               if (halt_req) begin
                  state <= S_IDLE;
               end else if (is_sentinel) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (branch_taken) begin
                  if (target_bad) begin
                     state <= S_DONE;
                     error <= 1'b1;
                  end else begin
                     pc_q <= target[ADDR_W-1:0];
                  end
               end else if (pc_q == ADDR_W'(DEPTH - 1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  pc_q <= pc_q + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_CYCLE_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 16'h0;
      end else if (start && state != S_RUN) begin
         count_q <= 16'h0;
      end else if (instr_valid && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'h1;
      end
   end

   assign cycle_count = count_q;
`else
   assign cycle_count = 16'h0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench for instr_sequencer with a program-level reference model
module tb_instr_sequencer;

   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;

   logic          clk;
   logic          rst;
   logic          load_valid;
   logic          load_ready;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          start;
   logic          halt_req;
   logic [31:0]   instr;
   logic          instr_valid;
   logic          branch_taken;
   logic [AW-1:0] pc;
   logic          done;
   logic          error;
   logic [15:0]   cycle_count;

   instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data),
      .start(start), .halt_req(halt_req),
      .instr(instr), .instr_valid(instr_valid),
      .branch_taken(branch_taken), .pc(pc),
      .done(done), .error(error), .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: program memory plus architectural state
   logic [31:0] mm [DEPTH];
   int          m_st, m_pc, m_cnt;
   bit          m_done, m_err;

   int          bt_pc = -1, bt_left = 0, halt_pc = -1, rl_addr = -1;
   logic [31:0] rl_data = 32'h0;
   int          issued[$];
   logic [31:0] seen[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_cnt();
`ifdef SEQ_CYCLE_COUNT_EN
      return 16'(m_cnt);
`else
      return 16'h0;
`endif
   endfunction

   function automatic logic [31:0] enc_beq(input int imm);
      logic [12:0] b;
      b = imm[12:0];
      return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'b1100011};
   endfunction

   function automatic int dec_imm(input logic [31:0] ins);
      return (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_pc = 0; m_cnt = 0; m_done = 0; m_err = 0;
   endtask

   task automatic compare();
      logic [31:0] e_instr;
      e_instr = (m_st == S_RUN) ? mm[m_pc] : 32'h0;
      chk("instr", instr, e_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_st == S_RUN && e_instr != 0));
      chk("load_ready", 32'(load_ready), 32'(m_st == S_IDLE));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("cycle_count", 32'(cycle_count), 32'(exp_cnt()));
   endtask

   task automatic model_step(input bit lv, input int la, input logic [31:0] ld,
                             input bit st, input bit hr, input bit bt);
      logic [31:0] ins;
      int imm, tgt;
      if (m_st == S_IDLE) begin
         if (lv) mm[la] = ld;
         if (st) begin m_st = S_RUN; m_pc = 0; m_done = 0; m_err = 0; m_cnt = 0; end
      end else if (m_st == S_RUN) begin
         ins = mm[m_pc];
         if (ins != 0 && m_cnt < 65535) m_cnt++;
         if (hr) m_st = S_IDLE;
         else if (ins == 0) begin m_st = S_DONE; m_done = 1; end
         else if (bt) begin
            imm = dec_imm(ins);
            tgt = m_pc + (imm >>> 2);
            if (tgt < 0 || tgt >= DEPTH || imm % 4 != 0) begin m_st = S_DONE; m_err = 1; end
            else m_pc = tgt;
         end else if (m_pc == DEPTH - 1) begin m_st = S_DONE; m_done = 1; end
         else m_pc++;
      end else begin
         if (st) begin m_st = S_RUN; m_pc = 0; m_done = 0; m_err = 0; m_cnt = 0; end
         else if (hr) begin m_st = S_IDLE; m_done = 0; m_err = 0; end
      end
   endtask

   // One clock: compare at the falling edge, drive inputs, advance model, pass the rising edge
   task automatic step(input bit lv, input int la, input logic [31:0] ld,
                       input bit st, input bit hr, input bit bt);
      @(negedge clk);
      compare();
      if (instr_valid) begin
         issued.push_back(int'(pc));
         seen.push_back(instr);
      end
      load_valid = lv; load_addr = la[AW-1:0]; load_data = ld;
      start = st; halt_req = hr; branch_taken = bt;
      model_step(lv, la, ld, st, hr, bt);
      @(posedge clk);
      #1;
      load_valid = 0; start = 0; halt_req = 0; branch_taken = 0;
   endtask

   task automatic load_word(input int a, input logic [31:0] d);
      step(1, a, d, 0, 0, 0);
   endtask

   task automatic go_idle();
      step(0, 0, 32'h0, 0, 1, 0);
   endtask

   task automatic run_prog(input int budget, input bit lv, input int la, input logic [31:0] ld);
      int n;
      bit bt, hr;
      n = 0;
      issued.delete();
      seen.delete();
      step(lv, la, ld, 1, 0, 0);
      while (m_st == S_RUN && n < budget) begin
         bt = (m_pc == bt_pc && bt_left > 0 && mm[m_pc] != 0);
         if (bt) bt_left--;
         hr = (m_pc == halt_pc);
         step(rl_addr >= 0, (rl_addr >= 0) ? rl_addr : 0, rl_data, 0, hr, bt);
         n++;
      end
      if (m_st == S_RUN) begin
         checks++;
         errors++;
         $display("FAIL run_budget: still running after %0d cycles, required to stop", budget);
      end
      step(0, 0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      int exp_seq[$];
      rst = 1; load_valid = 0; load_addr = '0; load_data = '0;
      start = 0; halt_req = 0; branch_taken = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", instr, 32'h0);
      chk("rst_load_ready", 32'(load_ready), 32'h1);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_cycle_count", 32'(cycle_count), 32'h0);
      compare();
      @(negedge clk);
      rst = 0;

      // Straight line; the sentinel write shares its cycle with start
      load_word(0, 32'h00500093);
      load_word(1, 32'h00108133);
      run_prog(20, 1, 2, 32'h0);
      chk("sl_issue_count", 32'(issued.size()), 32'd2);
      exp_seq = '{0, 1};
      foreach (exp_seq[i]) if (i < issued.size()) chk("sl_pc_seq", 32'(issued[i]), 32'(exp_seq[i]));
      chk("sl_done", 32'(done), 32'h1);
      chk("sl_error", 32'(error), 32'h0);
`ifdef SEQ_CYCLE_COUNT_EN
      chk("sl_cycle_count", 32'(cycle_count), 32'd2);
`endif

      // Backward branch taken once at word 3 (imm = -8)
      go_idle();
      for (int i = 0; i < 3; i++) load_word(i, 32'h00000013);
      load_word(3, enc_beq(-8));
      load_word(4, 32'h00000013);
      load_word(5, 32'h0);
      bt_pc = 3; bt_left = 1;
      run_prog(40, 0, 0, 32'h0);
      exp_seq = '{0, 1, 2, 3, 1, 2, 3, 4};
      chk("bb_issue_count", 32'(issued.size()), 32'd8);
      foreach (exp_seq[i]) if (i < issued.size()) chk("bb_pc_seq", 32'(issued[i]), 32'(exp_seq[i]));
      chk("bb_done", 32'(done), 32'h1);

      // Bad targets: beyond the buffer, then a half-word offset
      go_idle();
      load_word(0, 32'h00000013);
      load_word(1, enc_beq(64));
      load_word(2, 32'h00000013);
      bt_pc = 1; bt_left = 1;
      run_prog(20, 0, 0, 32'h0);
      chk("bad64_error", 32'(error), 32'h1);
      chk("bad64_done", 32'(done), 32'h0);
      chk("bad64_instr", instr, 32'h0);
      go_idle();
      load_word(1, enc_beq(6));
      bt_pc = 1; bt_left = 1;
      run_prog(20, 0, 0, 32'h0);
      chk("bad6_error", 32'(error), 32'h1);
      chk("bad6_done", 32'(done), 32'h0);
      bt_pc = -1;

      // Fall off the end, then restart directly from DONE
      go_idle();
      for (int i = 0; i < DEPTH; i++) load_word(i, 32'h00000013 | (32'(i) << 20));
      run_prog(40, 0, 0, 32'h0);
      chk("fo_issue_count", 32'(issued.size()), 32'd16);
      if (issued.size() == 16) chk("fo_last_pc", 32'(issued[15]), 32'd15);
      chk("fo_done", 32'(done), 32'h1);
`ifdef SEQ_CYCLE_COUNT_EN
      chk("fo_cycle_count", 32'(cycle_count), 32'd16);
`endif
      run_prog(40, 0, 0, 32'h0);
      chk("fo2_issue_count", 32'(issued.size()), 32'd16);

      // Halt at pc 2 with a load attempt during RUN that must be ignored
      halt_pc = 2; rl_addr = 5; rl_data = 32'hDEADBEEF;
      run_prog(40, 0, 0, 32'h0);
      halt_pc = -1; rl_addr = -1;
      chk("halt_load_ready", 32'(load_ready), 32'h1);
      chk("halt_done", 32'(done), 32'h0);
      chk("halt_instr", instr, 32'h0);
      run_prog(40, 0, 0, 32'h0);
      if (seen.size() > 5) chk("run_load_ignored", seen[5], 32'h00500013);
      go_idle();
      chk("done_halt_clears", 32'(done), 32'h0);
      load_word(5, 32'hDEADBEEF);
      run_prog(40, 0, 0, 32'h0);
      if (seen.size() > 5) chk("idle_load_taken", seen[5], 32'hDEADBEEF);
      else chk("idle_load_seen", 32'(seen.size()), 32'd16);

      // Asynchronous reset in the middle of a RUN cycle
      step(0, 0, 32'h0, 1, 0, 0);
      step(0, 0, 32'h0, 0, 0, 0);
      @(negedge clk);
      compare();
      chk("pre_rst_pc", 32'(pc), 32'h1);
      rst = 1;
      #1;
      chk("arst_instr", instr, 32'h0);
      chk("arst_pc", 32'(pc), 32'h0);
      chk("arst_valid", 32'(instr_valid), 32'h0);
      chk("arst_load_ready", 32'(load_ready), 32'h1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      step(0, 0, 32'h0, 0, 0, 0);
      step(0, 0, 32'h0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer for the single-cycle `riscv_simple` datapath. It holds a small program in an internal instruction buffer and drives one instruction per clock onto the datapath `instr` input. It redirects its program counter whenever the datapath reports `branch_taken`, and stops on a sentinel, on a fall-off-the-end, or on a bad branch target. It sits between the test/boot loader and the datapath and replaces hand-driven `instr` stimulus.

## Interface
Parameters:
- `DEPTH`, 16: number of 32-bit instruction words in the buffer; power of two, 4..256.
- `ADDR_W`, 4: log2(`DEPTH`); word-address width of `pc` and `load_addr`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  loader offers a write this cycle.
- `load_ready`  out  1  a write is accepted; 1 only in IDLE.
- `load_addr`  in  ADDR_W  word address of the write.
- `load_data`  in  32  instruction word to store.
- `start`  in  1  one-cycle pulse; begins execution from word 0.
- `halt_req`  in  1  abort execution and return to IDLE.
- `instr`  out  32  instruction to the datapath.
- `instr_valid`  out  1  `instr` is a live issue this cycle.
- `branch_taken`  in  1  from the datapath; refers to the `instr` issued in the same cycle.
- `pc`  out  ADDR_W  word address of the current instruction.
- `done`  out  1  program finished normally.
- `error`  out  1  program stopped on a bad branch target.
- `cycle_count`  out  16  count of issued instructions (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `load_ready`=1.
  - `load_valid` writes `load_data` to `mem[load_addr]` at the clock edge.
  - `start` moves to RUN with `pc`=0 and clears `done`, `error` and `cycle_count`.
  - `start` and `load_valid` in the same cycle: the write completes and RUN is entered.
- RUN:
  - `instr`=`mem[pc]`, read combinationally; `instr_valid`=1; `load_ready`=0; loads are ignored.
  - Branch immediate decoded from `instr`: imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - `branch_taken`=1: target = `pc` + imm[12:2], computed at ADDR_W+11 bits signed.
    - Target <0 or ≥`DEPTH`, or imm[1]=1 → DONE with `error`=1.
    - Otherwise `pc` ← target.
  - `branch_taken`=0: `pc`=`DEPTH`-1 → DONE with `done`=1; otherwise `pc` ← `pc`+1.
  - `instr`==32'h0 is the end-of-program sentinel:
    - It is not issued: `instr_valid`=0 that cycle.
    - Next state is DONE with `done`=1; `branch_taken` is ignored.
  - `halt_req` → IDLE. It has priority over every other RUN transition. `done` and `error` stay 0.
  - `start` is ignored.
- DONE:
  - `instr`=32'h0, `instr_valid`=0; `done`/`error` are held.
  - `start` → RUN, same effects as from IDLE.
  - `halt_req` → IDLE and clears `done` and `error`.
  - Buffer contents are preserved in every state.
- Outside RUN, `instr` is always 32'h0.

## Timing
- Reset values: state IDLE; `pc`=0, `instr`=0, `instr_valid`=0, `load_ready`=1, `done`=0, `error`=0, `cycle_count`=0.
- Buffer contents are not reset.
- Reset asserted mid-RUN forces IDLE immediately (asynchronous); the datapath sees `instr`=0 in the same cycle.
- Latency:
  - `start` at edge N → first instruction issued during cycle N+1.
  - A taken branch in cycle K → the target is issued in cycle K+1, with no bubble.
- A load write is visible to a `start` issued in the next cycle.
- `done`/`error` assert one cycle after the terminating instruction.
- `cycle_count` increments at each edge where `instr_valid`=1. It saturates at 16'hFFFF.

## Configuration
- `SEQ_CYCLE_COUNT_EN` defined: the `cycle_count` counter is built as described above.
- Not defined:
  - No counter logic is built.
  - The `cycle_count` port still exists and is tied to 16'h0.

## Test plan
- Straight line:
  - Load ADDI x1,x0,5; ADD x2,x1,x1; 0 at words 0..2; pulse `start`.
  - `instr_valid` is high for exactly 2 cycles, at `pc`=0 then 1.
  - `done`=1 in the cycle after `pc`=2; `cycle_count`=2 (`SEQ_CYCLE_COUNT_EN` defined).
- Backward branch:
  - Word 3 = BEQ with imm=-8, `branch_taken` forced 1 on its first issue only.
  - `pc` sequence 0,1,2,3,1,2,3,4; no bubble after the branch.
- Bad target:
  - Word 1 = BEQ imm=+64 (`DEPTH`=16), `branch_taken`=1.
  - Next cycle `error`=1, `done`=0, `instr`=0.
  - Same test with imm=+6 (imm[1]=1) → `error`=1.
- Fall-off:
  - Fill all 16 words with non-zero non-branch instructions.
  - `done`=1 after `pc`=15; `cycle_count`=16.
- Halt and reset:
  - Assert `halt_req` at `pc`=2 → IDLE next cycle, `load_ready`=1, `done`=0.
  - Restart, then assert `rst` mid-cycle at `pc`=1 → `instr`=0 and `pc`=0 immediately.
- Load handshake:
  - `load_valid` during RUN → `load_ready`=0 and the word is unchanged.
  - After `halt_req`, the same write is accepted and read back on the next run.
